image_writer: RTL

IMAGE_WRITER -- requirements
Module: image_writer

---
 rtl/image_writer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/image_writer.sv
// Streams bytes into an image RAM: one registered write per pixel, FRAME_LEN pixels per frame.
// Define IMAGE_WRITER_RLE_EN to decode (count, value) run-length pairs instead of raw pixels.
module image_writer #(
  parameter int FRAME_LEN = 64000,
  parameter int ADDR_W    = 16
) (
  input  logic              iclk,
  input  logic              irst_n,
  input  logic              istart,
  input  logic [7:0]        ipix,
  input  logic              ivalid,
  output logic              oready,
  output logic [ADDR_W-1:0] oaddr_wr,
  output logic [7:0]        odata,
  output logic              owr_en,
  output logic              obusy,
  output logic              odone,
  output logic              oerr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);

`ifdef IMAGE_WRITER_RLE_EN
  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt;
  logic              last_wr;
  logic              load_open;
  logic              accept;
`ifdef IMAGE_WRITER_RLE_EN
  logic [7:0]        run;
  logic              want_val;
`endif

  // The final write of the frame is on the bus: stop taking bytes this cycle.
  assign last_wr   = owr_en && (oaddr_wr == LAST);
  assign load_open = (state == LOAD) && !last_wr;
  assign accept    = ivalid && load_open;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    oready   = 1'b0;
    obusy    = 1'b0;
    odone    = 1'b0;
    case (state)
      IDLE: begin
        if (istart) state_nx = LOAD;
      end
      LOAD: begin
        obusy  = 1'b1;
        oready = load_open;
        if (istart)       state_nx = LOAD;
        else if (last_wr) state_nx = DONE;
`ifdef IMAGE_WRITER_RLE_EN
        else if (accept && want_val && (run != 8'd0) && (cnt != LAST))
          state_nx = EXPAND;
`endif
      end
`ifdef IMAGE_WRITER_RLE_EN
      EXPAND: begin
        obusy = 1'b1;
        // Leaving on the frame end lets LOAD see last_wr and move to DONE.
        if (istart || (run == 8'd1) || (cnt == LAST)) state_nx = LOAD;
      end
`endif
      DONE: begin
        odone    = 1'b1;
        state_nx = istart ? LOAD : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      cnt      <= '0;
      oaddr_wr <= '0;
      odata    <= '0;
      owr_en   <= 1'b0;
      oerr     <= 1'b0;
`ifdef IMAGE_WRITER_RLE_EN
      run      <= '0;
      want_val <= 1'b0;
`endif
    end else begin
      owr_en <= 1'b0;
      if (istart) begin
        // A start outside IDLE aborts a frame; any byte offered alongside is dropped.
        cnt  <= '0;
        oerr <= (state != IDLE);
`ifdef IMAGE_WRITER_RLE_EN
        run      <= '0;
        want_val <= 1'b0;
`endif
      end else if (accept) begin
`ifdef IMAGE_WRITER_RLE_EN
        if (!want_val) begin
          run      <= ipix;
          want_val <= 1'b1;
        end else begin
          want_val <= 1'b0;
          owr_en   <= 1'b1;
          oaddr_wr <= cnt;
          odata    <= ipix;
          cnt      <= cnt + ADDR_W'(1);
          if ((cnt == LAST) && (run != 8'd0)) oerr <= 1'b1;
        end
`else
        owr_en   <= 1'b1;
        oaddr_wr <= cnt;
        odata    <= ipix;
        cnt      <= cnt + ADDR_W'(1);
`endif
      end
`ifdef IMAGE_WRITER_RLE_EN
      else if (state == EXPAND) begin
        // odata still holds the run value; run counts the repeats left.
        owr_en   <= 1'b1;
        oaddr_wr <= cnt;
        cnt      <= cnt + ADDR_W'(1);
        run      <= run - 8'd1;
        if ((cnt == LAST) && (run > 8'd1)) oerr <= 1'b1;
      end
`endif
    end
  end

endmodule
